spike_rate_decoder: RTL

- Output-side counterpart to the LIF neuron network: converts the network's spike pulses back into numeric firing rates.
- Counts rising edges on each spike channel over a programmable window, then latches the counts as a result set.
- Presents each result set through a valid/ack handshake, with an overrun flag and an argmax "winner" index.
- Sits beside the network inside the tile wrapper and is driven by the spike_1/2/3/final lines.

---
 rtl/spike_rate_decoder.sv | 99 +++++++++
 1 files changed

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts rising edges per spike channel over a programmable window
// and hands each result set to a consumer through a valid/ack handshake.
module spike_rate_decoder #(
    parameter int NUM_CH   = 4,
    parameter int WIN_BITS = 8,
    parameter int CNT_BITS = 4,
    localparam int W_BITS  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       clear,
    input  logic [WIN_BITS-1:0]        window_len,
    input  logic [NUM_CH-1:0]          spike_in,
    input  logic                       rate_ack,
    output logic [NUM_CH*CNT_BITS-1:0] rate_out,
    output logic                       rate_valid,
    output logic [W_BITS-1:0]          winner,
    output logic                       overrun,
    output logic                       busy
);
    typedef enum logic {IDLE, COUNT} state_t;
    state_t state, state_nx;
    logic [NUM_CH-1:0] prev_spike, spk_edge;
    logic [NUM_CH-1:0][CNT_BITS-1:0] cnt, cnt_inc;
    logic [CNT_BITS-1:0] best;
    logic [WIN_BITS-1:0] win_cnt, win_len_q;
    logic [W_BITS-1:0] win_idx;
    logic run, start, win_end;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        run      = enable && !clear;
        start    = run && state == IDLE;
        win_end  = run && state == COUNT && win_cnt == win_len_q - 1'b1;
        state_nx = run ? COUNT : IDLE;
    end

    always_comb busy = state == COUNT;

    // Counters sit at zero in IDLE, so cnt_inc on the entry cycle is just that cycle's edges.
    always_comb begin
        spk_edge = spike_in & ~prev_spike;
        for (int i = 0; i < NUM_CH; i++)
            cnt_inc[i] = (&cnt[i]) ? cnt[i] : cnt[i] + spk_edge[i];
    end

    always_comb begin
        win_idx = '0;
        best    = cnt_inc[0];
        for (int i = 1; i < NUM_CH; i++)
            if (cnt_inc[i] > best) begin
                win_idx = W_BITS'(i);
                best    = cnt_inc[i];
            end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            prev_spike <= '0;
            cnt        <= '0;
            win_cnt    <= '0;
            win_len_q  <= '0;
        end else begin
            prev_spike <= spike_in;
            if (start || win_end) begin
                cnt       <= start ? cnt_inc : '0;
                win_cnt   <= '0;
                win_len_q <= window_len;
            end else if (run) begin
                cnt     <= cnt_inc;
                win_cnt <= win_cnt + 1'b1;
            end else begin
                cnt     <= '0;
                win_cnt <= '0;
            end
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rate_out   <= '0;
            winner     <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (clear) begin
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (win_end) begin
            rate_out   <= cnt_inc;
            winner     <= win_idx;
            rate_valid <= 1'b1;
            overrun    <= overrun || (rate_valid && !rate_ack);
        end else if (rate_ack) begin
            rate_valid <= 1'b0;
        end
endmodule
